// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the MIPS32 hazard stall/flush unit: stall-cause codes,
// HI/LO unit FSM states and the register-match helper.
package hazard_stall_unit_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    STALL_NONE    = 2'b00,
    STALL_LOADUSE = 2'b01,
    STALL_BRANCH  = 2'b10,
    STALL_MULDIV  = 2'b11
  } stall_cause_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // $zero never creates a dependence, and only sources the instruction reads count.
  function automatic logic reg_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (dst != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_muldiv_busy_tracker.sv
// HI/LO unit occupancy tracker: IDLE/BUSY FSM with a down-counter loaded with
// the operation latency minus one on issue.
module muldiv_busy_tracker
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic last
);

  localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   load_val;

  assign load_val = is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = load_val;
        end
      end
      MD_BUSY: begin
        // Final busy cycle accepts a new issue so back-to-back ops leave no gap.
        if (cnt_q == '0) begin
          if (start) cnt_d = load_val;
          else       state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy = (state_q == MD_BUSY);
  assign last = busy && (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for the 5-stage MIPS32 pipeline: load-use, ID-stage branch
// operand and HI/LO unit hazards, plus a saturating stalled-cycle counter.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_is_branch,
  input  logic             ID_is_muldiv,
  input  logic             ID_is_div,
  input  logic             ID_reads_hilo,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_MEM_MemRead,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             branch_taken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             muldiv_busy,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] stall_count
);

  logic         ex_dep, mem_dep;
  logic         hz_load, hz_branch, hz_muldiv, stall;
  logic         md_busy, md_last, md_start;
  stall_cause_e cause;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  assign ex_dep  = reg_match(ID_uses_rs, ID_rs, ID_EX_rd)  || reg_match(ID_uses_rt, ID_rt, ID_EX_rd);
  assign mem_dep = reg_match(ID_uses_rs, ID_rs, EX_MEM_rd) || reg_match(ID_uses_rt, ID_rt, EX_MEM_rd);

  assign hz_load   = ID_EX_MemRead && ex_dep;
  assign hz_branch = ID_is_branch && ((ID_EX_RegWrite && ex_dep) || (EX_MEM_MemRead && mem_dep));
  // The counter's final cycle does not stall: the result is readable once the op leaves ID.
  assign hz_muldiv = md_busy && !md_last && (ID_reads_hilo || ID_is_muldiv);
  assign stall     = hz_load || hz_branch || hz_muldiv;
  assign md_start  = ID_is_muldiv && !stall;

  muldiv_busy_tracker #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (ID_is_div),
    .busy   (md_busy),
    .last   (md_last)
  );

  always_comb begin
    cause = STALL_NONE;
    if      (hz_load)   cause = STALL_LOADUSE;
    else if (hz_branch) cause = STALL_BRANCH;
    else if (hz_muldiv) cause = STALL_MULDIV;
  end

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = branch_taken;
    ID_EX_Bubble = 1'b0;
    stall_cause  = cause;
    if (!rst_n || stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
    if (!rst_n) stall_cause = STALL_NONE;
  end

  assign muldiv_busy = md_busy;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule
